// File: rtl/led_sweeper_pkg.sv
// Shared definitions for the LED sweeper: pattern mode encodings and
// the position-width helper used by every instance.
package led_sweeper_pkg;

    typedef enum logic [1:0] {
        MODE_BOUNCE    = 2'd0,
        MODE_RING_UP   = 2'd1,
        MODE_RING_DOWN = 2'd2,
        MODE_FREEZE    = 2'd3
    } mode_e;

    // Width of a position index for a bank of w LEDs, never below one bit.
    function automatic int pos_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/led_sweeper_tick_div.sv
// Step prescaler: emits one tick every (i_div + 1) enabled clocks.
// The tick uses a >= compare so that lowering i_div mid-count ticks on
// the very next enabled clock instead of running the counter around.
module led_tick_div #(
    parameter int DIV_W = 24
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_en,
    input  logic [DIV_W-1:0] i_div,
    output logic             o_tick
);

    logic [DIV_W-1:0] cnt_q, cnt_d;

    // Tick decision and next count; count holds while disabled.
    always_comb begin
        o_tick = i_en && (cnt_q >= i_div);
        cnt_d  = cnt_q;
        if (i_en) begin
            cnt_d = o_tick ? '0 : cnt_q + DIV_W'(1);
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/led_sweeper.sv
// One-hot LED position generator. A single lit LED moves across a
// WIDTH-bit bank on prescaled ticks in bounce, ring-up, ring-down or
// freeze patterns. All outputs come straight from registers.
module led_sweeper
    import led_sweeper_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIV_W = 24,
    localparam int POS_W = pos_width(WIDTH)
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_en,
    input  logic [1:0]       i_mode,
    input  logic [DIV_W-1:0] i_div,
    output logic [WIDTH-1:0] o_led,
    output logic [POS_W-1:0] o_pos,
    output logic             o_dir,
    output logic             o_wrap
);

    localparam logic [POS_W-1:0] POS_MAX = POS_W'(WIDTH - 1);

    logic             tick;
    mode_e            mode;
    logic             go_up;
    logic [POS_W-1:0] pos_q, pos_d;
    logic             dir_q, dir_d;
    logic             wrap_q, wrap_d;
    logic [WIDTH-1:0] led_q, led_d;

    led_tick_div #(
        .DIV_W (DIV_W)
    ) u_tick_div (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_en    (i_en),
        .i_div   (i_div),
        .o_tick  (tick)
    );

    // Mode is only acted upon on a tick, so it needs no separate register.
    always_comb mode = mode_e'(i_mode);

    // Next position/direction/wrap; the one-hot drive is decoded from the
    // next position so it lands on the same edge as o_pos.
    always_comb begin
        pos_d  = pos_q;
        dir_d  = dir_q;
        wrap_d = 1'b0;
        go_up  = 1'b0;
        if (tick) begin
            case (mode)
                MODE_BOUNCE: begin
                    // The ends override the stored direction so a pattern
                    // entered at either end never tries to step off the bank.
                    if (pos_q == '0) begin
                        go_up = 1'b1;
                    end else if (pos_q == POS_MAX) begin
                        go_up = 1'b0;
                    end else begin
                        go_up = !dir_q;
                    end
                    if (go_up) begin
                        pos_d = pos_q + POS_W'(1);
                        dir_d = (pos_d == POS_MAX);
                    end else begin
                        pos_d  = pos_q - POS_W'(1);
                        dir_d  = (pos_d != '0);
                        wrap_d = (pos_d == '0);
                    end
                end
                MODE_RING_UP: begin
                    dir_d = 1'b0;
                    if (pos_q == POS_MAX) begin
                        pos_d  = '0;
                        wrap_d = 1'b1;
                    end else begin
                        pos_d = pos_q + POS_W'(1);
                    end
                end
                MODE_RING_DOWN: begin
                    dir_d = 1'b1;
                    if (pos_q == '0) begin
                        pos_d  = POS_MAX;
                        wrap_d = 1'b1;
                    end else begin
                        pos_d = pos_q - POS_W'(1);
                    end
                end
                default: begin
                    // Freeze: position and direction hold, no wrap.
                end
            endcase
        end
        led_d = WIDTH'(1) << pos_d;
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            pos_q  <= '0;
            dir_q  <= 1'b0;
            wrap_q <= 1'b0;
            led_q  <= WIDTH'(1);
        end else begin
            pos_q  <= pos_d;
            dir_q  <= dir_d;
            wrap_q <= wrap_d;
            led_q  <= led_d;
        end
    end

    assign o_led  = led_q;
    assign o_pos  = pos_q;
    assign o_dir  = dir_q;
    assign o_wrap = wrap_q;

endmodule
